// File: rtl/bcd_ctrl_pkg.sv
// bcd_ctrl_pkg: register offsets, bit indices and FSM state type for apb_bcd_ctrl
package bcd_ctrl_pkg;
  localparam logic [7:0] OFF_ARG1   = 8'h00;
  localparam logic [7:0] OFF_ARG2   = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_RESULT = 8'h10;
  localparam logic [7:0] OFF_IRQEN  = 8'h14;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVF  = 2;
  localparam int ST_ERR  = 3;
  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAITB, RUN} state_t;
endpackage

// File: rtl/bcd_digit_check.sv
// bcd_digit_check: flags whether every nibble of i_arg is a valid BCD digit
// i_arg   operand to inspect
// o_valid 1 when all nibbles are <= 9
import bcd_ctrl_pkg::*;
module bcd_digit_check #(
  parameter int ARG_W = 32
) (
  input  logic [ARG_W-1:0] i_arg,
  output logic             o_valid
);
  always_comb begin
    o_valid = 1'b1;
    for (int i = 0; i < ARG_W / 4; i++)
      if (i_arg[4*i +: 4] > 4'd9) o_valid = 1'b0;
  end
endmodule

// File: rtl/apb_bcd_ctrl.sv
// apb_bcd_ctrl: APB3 register front end that launches and supervises the BCD adder
// clk/resetn            clock, synchronous active-low reset
// psel..pslverr         APB3 slave port, zero wait states
// add_arg1/2, add_start operands and one-cycle launch pulse to the adder
// add_busy/result/ovf   adder handshake and result
// irq                   done interrupt, only when BCD_CTRL_IRQ_EN is defined (else tied 0)
import bcd_ctrl_pkg::*;
module apb_bcd_ctrl #(
  parameter int ARG_W   = 32,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [ARG_W-1:0]  add_arg1,
  output logic [ARG_W-1:0]  add_arg2,
  output logic              add_start,
  input  logic              add_busy,
  input  logic [ARG_W-1:0]  add_result,
  input  logic              add_overflow,
  output logic              irq
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t           r_state;
  logic [ARG_W-1:0] r_arg1, r_arg2, r_result;
  logic             r_done, r_ovf, r_err, r_start;
  logic [CW-1:0]    r_cnt;
  logic             w_acc, w_wr, w_busy, w_v1, w_v2, w_bad, w_wr_err, w_start, w_clr, w_expire;
  logic             w_hit_arg1, w_hit_arg2, w_hit_ctrl, w_hit_stat, w_hit_res, w_hit_irqen;
  logic [31:0]      w_status, w_irqen_rd;
  bcd_digit_check #(.ARG_W(ARG_W)) u_chk1 (.i_arg(r_arg1), .o_valid(w_v1));
  bcd_digit_check #(.ARG_W(ARG_W)) u_chk2 (.i_arg(r_arg2), .o_valid(w_v2));
  assign w_acc      = psel & penable;
  assign w_wr       = w_acc & pwrite;
  assign w_busy     = r_state != IDLE;
  assign w_hit_arg1 = paddr == ADDR_W'(OFF_ARG1);
  assign w_hit_arg2 = paddr == ADDR_W'(OFF_ARG2);
  assign w_hit_ctrl = paddr == ADDR_W'(OFF_CTRL);
  assign w_hit_stat = paddr == ADDR_W'(OFF_STATUS);
  assign w_hit_res  = paddr == ADDR_W'(OFF_RESULT);
`ifdef BCD_CTRL_IRQ_EN
  logic r_irqen, r_irq;
  assign w_hit_irqen = paddr == ADDR_W'(OFF_IRQEN);
  assign w_irqen_rd  = {31'd0, r_irqen};
  assign irq         = r_irq;
`else
  assign w_hit_irqen = 1'b0;
  assign w_irqen_rd  = '0;
  assign irq         = 1'b0;
`endif
  assign w_bad    = ~(w_hit_arg1 | w_hit_arg2 | w_hit_ctrl | w_hit_stat | w_hit_res | w_hit_irqen);
  // operand and launch writes are rejected while an operation is in flight
  assign w_wr_err = w_wr & w_busy & (w_hit_arg1 | w_hit_arg2 | (w_hit_ctrl & pwdata[CTRL_START]));
  assign w_start  = w_wr & ~w_busy & w_hit_ctrl & pwdata[CTRL_START];
  assign w_clr    = w_wr & w_hit_ctrl & pwdata[CTRL_CLR];
  assign w_expire = r_cnt == CW'(1);
  assign pready   = 1'b1;
  assign pslverr  = w_acc & (w_bad | w_wr_err);
  assign add_arg1 = r_arg1;
  assign add_arg2 = r_arg2;
  assign add_start = r_start;
  always_comb begin
    w_status          = '0;
    w_status[ST_BUSY] = w_busy;
    w_status[ST_DONE] = r_done;
    w_status[ST_OVF]  = r_ovf;
    w_status[ST_ERR]  = r_err;
  end
  assign prdata = w_hit_arg1  ? 32'(r_arg1) :
                  w_hit_arg2  ? 32'(r_arg2) :
                  w_hit_stat  ? w_status :
                  w_hit_res   ? 32'(r_result) :
                  w_hit_irqen ? w_irqen_rd : '0;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_arg1   <= '0;
      r_arg2   <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
      r_start  <= 1'b0;
      r_cnt    <= '0;
`ifdef BCD_CTRL_IRQ_EN
      r_irqen  <= 1'b0;
      r_irq    <= 1'b0;
`endif
    end else begin
      if (w_wr & ~w_busy & w_hit_arg1) r_arg1 <= pwdata[ARG_W-1:0];
      if (w_wr & ~w_busy & w_hit_arg2) r_arg2 <= pwdata[ARG_W-1:0];
`ifdef BCD_CTRL_IRQ_EN
      if (w_wr & w_hit_irqen) r_irqen <= pwdata[0];
      r_irq <= r_irqen & r_done & ~w_clr & ~w_start;
`endif
      // CLR is applied first so a same-cycle completion below overrides it
      if (w_clr) begin
        r_done <= 1'b0;
        r_ovf  <= 1'b0;
        r_err  <= 1'b0;
      end
      r_start <= 1'b0;
      case (r_state)
        IDLE: if (w_start) begin
          if (w_v1 & w_v2) begin
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_start <= 1'b1;
            r_state <= LAUNCH;
          end else begin
            r_err  <= 1'b1;
            r_done <= 1'b1;
          end
        end
        LAUNCH: begin
          r_cnt   <= CW'(TIMEOUT);
          r_state <= WAITB;
        end
        WAITB: if (w_expire) begin
          r_err   <= 1'b1;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt - CW'(1);
          if (add_busy) r_state <= RUN;
        end
        RUN: if (!add_busy) begin
          r_result <= add_result;
          r_ovf    <= add_overflow;
          r_done   <= 1'b1;
          r_state  <= IDLE;
        end else if (w_expire) begin
          r_err   <= 1'b1;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_bcd_ctrl.sv
// tb_apb_bcd_ctrl: scoreboard bench for apb_bcd_ctrl with a behavioural BCD adder
module tb_apb_bcd_ctrl;
  localparam logic [4:0] A_ARG1 = 5'h00, A_ARG2 = 5'h04, A_CTRL = 5'h08, A_STAT = 5'h0C, A_RES = 5'h10, A_IRQEN = 5'h14;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [4:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [31:0] add_arg1, add_arg2, add_result = '0;
  logic        add_start, add_busy = 1'b0, add_overflow = 1'b0, irq;
  int          n_chk = 0, n_fail = 0, n_start = 0, lat = 16, m_cnt = 0;
  typedef struct {
    string       nm;
    logic [31:0] d;
    logic [31:0] dm;
    logic        e;
    bit          em;
  } exp_t;
  exp_t sb[$];

  apb_bcd_ctrl dut (
    .clk(clk), .resetn(resetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .add_arg1(add_arg1), .add_arg2(add_arg2), .add_start(add_start), .add_busy(add_busy),
    .add_result(add_result), .add_overflow(add_overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] bcd_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    int c, d;
    s = '0;
    c = 0;
    for (int i = 0; i < 8; i++) begin
      d = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
      c = d > 9 ? 1 : 0;
      if (d > 9) d = d - 10;
      s[4*i +: 4] = 4'(d);
    end
    return {c[0], s};
  endfunction

  always @(posedge clk) begin
    if (add_start) n_start <= n_start + 1;
    if (m_cnt > 0) begin
      if (m_cnt == 1) add_busy <= 1'b0;
      m_cnt <= m_cnt - 1;
    end else if (add_start) begin
      add_busy <= 1'b1;
      m_cnt <= lat;
      {add_overflow, add_result} <= bcd_add(add_arg1, add_arg2);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (psel && penable) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.dm != 0) chk({e.nm, "_data"}, prdata & e.dm, e.d & e.dm);
        if (e.em) chk({e.nm, "_err"}, {31'd0, pslverr}, {31'd0, e.e});
      end
    end
  end

  task automatic apb(input bit wr, input logic [4:0] a, input logic [31:0] d, input string nm,
                     input logic [31:0] ed, input logic [31:0] dm, input logic ee, input bit em,
                     output logic [31:0] rd);
    exp_t e;
    e.nm = nm; e.d = ed; e.dm = dm; e.e = ee; e.em = em;
    sb.push_back(e);
    @(posedge clk) #1;
    psel = 1'b1; pwrite = wr; paddr = a; pwdata = d; penable = 1'b0;
    @(posedge clk) #1;
    penable = 1'b1;
    @(negedge clk);
    rd = prdata;
    @(posedge clk) #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input string nm, input logic ee);
    logic [31:0] x;
    apb(1'b1, a, d, nm, '0, '0, ee, 1'b1, x);
  endtask

  task automatic rd(input logic [4:0] a, input string nm, input logic [31:0] ed, input logic ee);
    logic [31:0] x;
    apb(1'b0, a, '0, nm, ed, 32'hFFFF_FFFF, ee, 1'b1, x);
  endtask

  task automatic wait_done(input string nm);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 100 && !s[1]; i++) apb(1'b0, A_STAT, '0, "poll", '0, '0, 1'b0, 1'b0, s);
    chk({nm, "_done_seen"}, {31'd0, s[1]}, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    rd(A_ARG1, "rst_arg1", 32'h0, 1'b0);
    rd(A_STAT, "rst_status", 32'h0, 1'b0);
    rd(A_RES, "rst_result", 32'h0, 1'b0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_start", {31'd0, add_start}, 32'd0);
    // basic add
    wr(A_ARG1, 32'h35, "t1_wr_arg1", 1'b0);
    wr(A_ARG2, 32'h78, "t1_wr_arg2", 1'b0);
    rd(A_ARG1, "t1_rb_arg1", 32'h35, 1'b0);
    n_start = 0;
    wr(A_CTRL, 32'h1, "t1_start", 1'b0);
    wait_done("t1");
    rd(A_STAT, "t1_status", 32'h2, 1'b0);
    rd(A_RES, "t1_result", 32'h113, 1'b0);
    chk("t1_start_cycles", n_start, 1);
    // carry out of the top digit
    wr(A_ARG1, 32'h9999_9999, "t2_wr_arg1", 1'b0);
    wr(A_ARG2, 32'h1, "t2_wr_arg2", 1'b0);
    wr(A_CTRL, 32'h1, "t2_start", 1'b0);
    wait_done("t2");
    rd(A_STAT, "t2_status", 32'h6, 1'b0);
    rd(A_RES, "t2_result", 32'h0, 1'b0);
    // writes while busy
    wr(A_ARG1, 32'h22, "t3_wr_arg1", 1'b0);
    wr(A_ARG2, 32'h33, "t3_wr_arg2", 1'b0);
    n_start = 0;
    wr(A_CTRL, 32'h1, "t3_start", 1'b0);
    wr(A_ARG1, 32'h11, "t3_busy_arg1", 1'b1);
    rd(A_STAT, "t3_busy_status", 32'h1, 1'b0);
    wr(A_CTRL, 32'h1, "t3_busy_start", 1'b1);
    wait_done("t3");
    rd(A_ARG1, "t3_arg1_kept", 32'h22, 1'b0);
    rd(A_RES, "t3_result", 32'h55, 1'b0);
    chk("t3_start_cycles", n_start, 1);
    // non-BCD operand and bad offsets
    wr(A_ARG1, 32'h1A, "t4_wr_arg1", 1'b0);
    n_start = 0;
    wr(A_CTRL, 32'h1, "t4_start", 1'b0);
    rd(A_STAT, "t4_status", 32'hA, 1'b0);
    repeat (5) @(posedge clk);
    chk("t4_no_launch", n_start, 0);
    rd(5'h18, "t4_bad_off", 32'h0, 1'b1);
    rd(A_RES, "t4_result_kept", 32'h55, 1'b0);
    wr(A_CTRL, 32'h2, "t4_clr", 1'b0);
    rd(A_STAT, "t4_status_clr", 32'h0, 1'b0);
`ifndef BCD_CTRL_IRQ_EN
    rd(A_IRQEN, "t4_irqen_absent", 32'h0, 1'b1);
`endif
    // timeout, then reset mid-operation
    lat = 100;
    wr(A_ARG1, 32'h1, "t5_wr_arg1", 1'b0);
    wr(A_CTRL, 32'h1, "t5_start", 1'b0);
    repeat (55) @(posedge clk);
    rd(A_STAT, "t5_still_busy", 32'h1, 1'b0);
    repeat (10) @(posedge clk);
    rd(A_STAT, "t5_timeout", 32'hA, 1'b0);
    wr(A_CTRL, 32'h1, "t5_restart", 1'b0);
    repeat (4) @(posedge clk);
    rd(A_STAT, "t5_busy_again", 32'h1, 1'b0);
    @(posedge clk) #1 resetn = 1'b0;
    @(posedge clk) #1 resetn = 1'b1;
    rd(A_STAT, "t5_rst_status", 32'h0, 1'b0);
    rd(A_RES, "t5_rst_result", 32'h0, 1'b0);
    rd(A_ARG1, "t5_rst_arg1", 32'h0, 1'b0);
    chk("t5_rst_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 200 && add_busy; i++) @(posedge clk);
    chk("t5_adder_idle", {31'd0, add_busy}, 32'd0);
    repeat (3) @(posedge clk);
    rd(A_STAT, "t5_late_fall", 32'h0, 1'b0);
    lat = 16;
`ifdef BCD_CTRL_IRQ_EN
    wr(A_IRQEN, 32'h1, "t6_irqen", 1'b0);
    wr(A_ARG1, 32'h2340_6568, "t6_wr_arg1", 1'b0);
    wr(A_ARG2, 32'h7900_0000, "t6_wr_arg2", 1'b0);
    wr(A_CTRL, 32'h1, "t6_start", 1'b0);
    chk("t6_irq_low", {31'd0, irq}, 32'd0);
    wait_done("t6");
    repeat (2) @(posedge clk);
    #1 chk("t6_irq_high", {31'd0, irq}, 32'd1);
    rd(A_RES, "t6_result", 32'h0240_6568, 1'b0);
    rd(A_STAT, "t6_status", 32'h6, 1'b0);
    wr(A_CTRL, 32'h2, "t6_clr", 1'b0);
    #1 chk("t6_irq_clr", {31'd0, irq}, 32'd0);
    rd(A_STAT, "t6_status_clr", 32'h0, 1'b0);
`else
    wr(A_ARG1, 32'h2340_6568, "t6_wr_arg1", 1'b0);
    wr(A_ARG2, 32'h7900_0000, "t6_wr_arg2", 1'b0);
    wr(A_CTRL, 32'h1, "t6_start", 1'b0);
    wait_done("t6");
    rd(A_RES, "t6_result", 32'h0240_6568, 1'b0);
    rd(A_STAT, "t6_status", 32'h6, 1'b0);
    chk("t6_irq_tied", {31'd0, irq}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
